// File: rtl/rlv12.sv
// RLV12-style disk controller: register file, command FSM and word-at-a-time
// transfer engine between a disk image port (rlmem*) and PDP-11 memory (rldma*).
module rlv12 #(
    parameter int          NDRIVES    = 4,
    parameter int          SECTORS    = 40,
    parameter int          SECT_WORDS = 128,
    parameter int          TRACKS     = 1024,
    parameter logic [31:0] IMG_BASE   = 32'h0,
    parameter int          TIMEOUT    = 4096
) (
    input  logic        clk,
    input  logic        busrst,
    input  logic        rlreq,
    input  logic [2:0]  rladdr,
    input  logic        rlwr,
    input  logic [15:0] rlwdata,
    output logic        rlack,
    output logic [15:0] rlrdata,
    output logic        rlirq,
    output logic        rlmemreq,
    output logic        rlmemwr,
    output logic [31:0] rlmemaddr,
    output logic [15:0] rlmemwdata,
    input  logic        rlmemack,
    input  logic [15:0] rlmemrdata,
    output logic        rldmareq,
    output logic        rldmawr,
    output logic [21:0] rldmaaddr,
    output logic [15:0] rldmawdata,
    input  logic        rldmaack,
    input  logic [15:0] rldmardata,
    input  logic        rldmanxm
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_DMA_RD, S_MEM_WR, S_MEM_RD, S_DMA_WR
    } state_t;

    localparam logic [3:0]        E_OPI     = 4'b0001;
    localparam logic [3:0]        E_WCE     = 4'b0010;
    localparam logic [3:0]        E_HNF     = 4'b0101;
    localparam logic [3:0]        E_NXM     = 4'b1000;
    localparam logic [31:0]       DRV_BYTES = 32'(TRACKS * SECTORS * SECT_WORDS * 2);
    localparam logic [31:0]       SEC_BYTES = 32'(SECT_WORDS * 2);
    localparam logic signed [11:0] TMAX     = 12'(TRACKS - 1);
    localparam int                TW        = $clog2(TIMEOUT + 1);

    state_t      r_state;
    logic [2:0]  r_f;
    logic [1:0]  r_ds;
    logic        r_ie;
    logic        r_crdy;
    logic [3:0]  r_e;
    logic [15:0] r_ba;
    logic [15:0] r_da;
    logic [15:0] r_mp;
    logic [5:0]  r_bae;
    logic [9:0]  r_trk [4];
    logic [31:0] r_memaddr;
    logic        r_pend;
    logic [TW-1:0] r_tmr;
    logic [15:0] r_memdata;
    logic [15:0] r_dmadata;
    logic        r_memreq, r_memwr, r_dmareq, r_dmawr;
    logic        r_irq, r_ack;
    logic [15:0] r_rdata;

    logic        w_dsok;
    logic        w_drdy;
    logic [15:0] w_csr;
    logic [9:0]  w_trk;
    logic [11:0] w_trk12, w_dist12;
    logic signed [11:0] w_sum;
    logic [9:0]  w_sat;
    logic [9:0]  w_seek_trk;
    logic [31:0] w_lba;
    logic [31:0] w_addr;
    logic        w_hnf;
    logic [15:0] w_mp_n;
    logic [21:0] w_ba_n;
    logic        w_tmo;

    assign w_dsok = int'(r_ds) < NDRIVES;
    assign w_drdy = w_dsok && (r_state == S_IDLE);
    assign w_csr  = {|r_e, 1'b0, r_e, r_ds, r_crdy, r_ie, r_bae[1:0], r_f, w_drdy};
    assign w_trk  = w_dsok ? r_trk[r_ds] : 10'd0;

    // Seek moves the cylinder by DA[15:7], clamps to the drive, then applies the head bit.
    assign w_trk12    = {2'b00, w_trk};
    assign w_dist12   = {2'b00, r_da[15:7], 1'b0};
    assign w_sum      = r_da[2] ? $signed(w_trk12 + w_dist12) : $signed(w_trk12 - w_dist12);
    assign w_sat      = w_sum[11] ? 10'd0 : ((w_sum > TMAX) ? TMAX[9:0] : w_sum[9:0]);
    assign w_seek_trk = {w_sat[9:1], r_da[4]};

    assign w_lba  = {26'd0, r_da[5:0]} + 32'(SECTORS) * {22'd0, r_da[15:6]};
    assign w_addr = IMG_BASE + {30'd0, r_ds} * DRV_BYTES + w_lba * SEC_BYTES;
    assign w_hnf  = ({26'd0, r_da[5:0]} >= 32'(SECTORS)) || ({22'd0, r_da[15:6]} >= 32'(TRACKS));

    assign w_mp_n = r_mp + 16'd1;
    assign w_ba_n = {r_bae, r_ba} + 22'd2;
    assign w_tmo  = (r_tmr == TW'(TIMEOUT - 1));

    assign rlack      = r_ack;
    assign rlrdata    = r_rdata;
    assign rlirq      = r_irq;
    assign rlmemreq   = r_memreq;
    assign rlmemwr    = r_memwr;
    assign rlmemaddr  = r_memaddr;
    assign rlmemwdata = r_dmadata;
    assign rldmareq   = r_dmareq;
    assign rldmawr    = r_dmawr;
    assign rldmaaddr  = {r_bae, r_ba};
    assign rldmawdata = r_memdata;

    // Register interface plus command/transfer FSM; FSM updates come last so they win over bus writes.
    always_ff @(posedge clk) begin
        if (busrst) begin
            r_state   <= S_IDLE;
            r_f       <= 3'd0;
            r_ds      <= 2'd0;
            r_ie      <= 1'b0;
            r_crdy    <= 1'b1;
            r_e       <= 4'd0;
            r_ba      <= 16'd0;
            r_da      <= 16'd0;
            r_mp      <= 16'd0;
            r_bae     <= 6'd0;
            for (int i = 0; i < 4; i++) r_trk[i] <= 10'd0;
            r_memaddr <= 32'd0;
            r_pend    <= 1'b0;
            r_tmr     <= '0;
            r_memdata <= 16'd0;
            r_dmadata <= 16'd0;
            r_memreq  <= 1'b0;
            r_memwr   <= 1'b0;
            r_dmareq  <= 1'b0;
            r_dmawr   <= 1'b0;
            r_irq     <= 1'b0;
            r_ack     <= 1'b0;
            r_rdata   <= 16'd0;
        end else begin
            r_ack    <= rlreq;
            r_irq    <= 1'b0;
            r_memreq <= 1'b0;
            r_dmareq <= 1'b0;

            if (rlreq) begin
                case (rladdr)
                    3'd0:    r_rdata <= w_csr;
                    3'd1:    r_rdata <= r_ba;
                    3'd2:    r_rdata <= r_da;
                    3'd3:    r_rdata <= r_mp;
                    3'd4:    r_rdata <= {10'd0, r_bae};
                    default: r_rdata <= 16'd0;
                endcase
            end

            if (rlreq && rlwr) begin
                case (rladdr)
                    3'd0: begin
                        r_ie <= rlwdata[6];
                        if (r_crdy) begin
                            r_f        <= rlwdata[3:1];
                            r_ds       <= rlwdata[9:8];
                            r_bae[1:0] <= rlwdata[5:4];
                            if (rlwdata[6] && !r_ie) r_irq <= 1'b1;
                            if (!rlwdata[7]) begin
                                r_crdy  <= 1'b0;
                                r_e     <= 4'd0;
                                r_state <= S_CMD;
                            end
                        end
                    end
                    3'd1: if (r_crdy) r_ba  <= rlwdata;
                    3'd2: if (r_crdy) r_da  <= rlwdata;
                    3'd3: if (r_crdy) r_mp  <= rlwdata;
                    3'd4: if (r_crdy) r_bae <= rlwdata[5:0];
                    default: ;
                endcase
            end

            case (r_state)
                S_CMD: begin
                    r_pend <= 1'b0;
                    if (!w_dsok) begin
                        r_e <= E_OPI;
                        r_crdy <= 1'b1; r_state <= S_IDLE; r_irq <= r_ie;
                    end else begin
                        case (r_f)
                            3'd0: begin
                                r_crdy <= 1'b1; r_state <= S_IDLE; r_irq <= r_ie;
                            end
                            3'd2: begin
                                r_mp <= 16'o235 | {9'd0, w_trk[0], 6'd0};
                                r_crdy <= 1'b1; r_state <= S_IDLE; r_irq <= r_ie;
                            end
                            3'd3: begin
                                if (!r_da[0]) r_e <= E_OPI;
                                else          r_trk[r_ds] <= w_seek_trk;
                                r_crdy <= 1'b1; r_state <= S_IDLE; r_irq <= r_ie;
                            end
                            3'd4: begin
                                r_mp <= {w_trk, 6'd0};
                                r_crdy <= 1'b1; r_state <= S_IDLE; r_irq <= r_ie;
                            end
                            default: begin
                                if (w_hnf) begin
                                    r_e <= E_HNF;
                                    r_crdy <= 1'b1; r_state <= S_IDLE; r_irq <= r_ie;
                                end else if (r_mp == 16'd0) begin
                                    r_crdy <= 1'b1; r_state <= S_IDLE; r_irq <= r_ie;
                                end else begin
                                    r_memaddr <= w_addr;
                                    r_state   <= (r_f == 3'd5) ? S_DMA_RD : S_MEM_RD;
                                end
                            end
                        endcase
                    end
                end

                // Fetch a word from PDP-11 memory: source for disk write, reference for write-check.
                S_DMA_RD: begin
                    if (!r_pend) begin
                        r_dmareq <= 1'b1; r_dmawr <= 1'b0; r_pend <= 1'b1; r_tmr <= '0;
                    end else if (rldmaack) begin
                        r_pend <= 1'b0;
                        if (rldmanxm) begin
                            r_e <= E_NXM;
                            r_crdy <= 1'b1; r_state <= S_IDLE; r_irq <= r_ie;
                        end else if (r_f == 3'd1) begin
                            // Compared word is counted even when it miscompares.
                            r_mp <= w_mp_n; {r_bae, r_ba} <= w_ba_n; r_memaddr <= r_memaddr + 32'd2;
                            if (rldmardata != r_memdata) begin
                                r_e <= E_WCE;
                                r_crdy <= 1'b1; r_state <= S_IDLE; r_irq <= r_ie;
                            end else if (w_mp_n == 16'd0) begin
                                r_crdy <= 1'b1; r_state <= S_IDLE; r_irq <= r_ie;
                            end else begin
                                r_state <= S_MEM_RD;
                            end
                        end else begin
                            r_dmadata <= rldmardata;
                            r_state   <= S_MEM_WR;
                        end
                    end else if (w_tmo) begin
                        r_pend <= 1'b0; r_e <= E_OPI;
                        r_crdy <= 1'b1; r_state <= S_IDLE; r_irq <= r_ie;
                    end else begin
                        r_tmr <= r_tmr + 1'b1;
                    end
                end

                S_MEM_WR: begin
                    if (!r_pend) begin
                        r_memreq <= 1'b1; r_memwr <= 1'b1; r_pend <= 1'b1; r_tmr <= '0;
                    end else if (rlmemack) begin
                        r_pend <= 1'b0;
                        r_mp <= w_mp_n; {r_bae, r_ba} <= w_ba_n; r_memaddr <= r_memaddr + 32'd2;
                        if (w_mp_n == 16'd0) begin
                            r_crdy <= 1'b1; r_state <= S_IDLE; r_irq <= r_ie;
                        end else begin
                            r_state <= S_DMA_RD;
                        end
                    end else if (w_tmo) begin
                        r_pend <= 1'b0; r_e <= E_OPI;
                        r_crdy <= 1'b1; r_state <= S_IDLE; r_irq <= r_ie;
                    end else begin
                        r_tmr <= r_tmr + 1'b1;
                    end
                end

                S_MEM_RD: begin
                    if (!r_pend) begin
                        r_memreq <= 1'b1; r_memwr <= 1'b0; r_pend <= 1'b1; r_tmr <= '0;
                    end else if (rlmemack) begin
                        r_pend    <= 1'b0;
                        r_memdata <= rlmemrdata;
                        r_state   <= (r_f == 3'd1) ? S_DMA_RD : S_DMA_WR;
                    end else if (w_tmo) begin
                        r_pend <= 1'b0; r_e <= E_OPI;
                        r_crdy <= 1'b1; r_state <= S_IDLE; r_irq <= r_ie;
                    end else begin
                        r_tmr <= r_tmr + 1'b1;
                    end
                end

                S_DMA_WR: begin
                    if (!r_pend) begin
                        r_dmareq <= 1'b1; r_dmawr <= 1'b1; r_pend <= 1'b1; r_tmr <= '0;
                    end else if (rldmaack) begin
                        r_pend <= 1'b0;
                        if (rldmanxm) begin
                            r_e <= E_NXM;
                            r_crdy <= 1'b1; r_state <= S_IDLE; r_irq <= r_ie;
                        end else begin
                            r_mp <= w_mp_n; {r_bae, r_ba} <= w_ba_n; r_memaddr <= r_memaddr + 32'd2;
                            if (w_mp_n == 16'd0) begin
                                r_crdy <= 1'b1; r_state <= S_IDLE; r_irq <= r_ie;
                            end else begin
                                r_state <= S_MEM_RD;
                            end
                        end
                    end else if (w_tmo) begin
                        r_pend <= 1'b0; r_e <= E_OPI;
                        r_crdy <= 1'b1; r_state <= S_IDLE; r_irq <= r_ie;
                    end else begin
                        r_tmr <= r_tmr + 1'b1;
                    end
                end

                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rlv12.sv
// Directed bench for rlv12 (NDRIVES=2): register file, transfers, seek/header, error paths.
module tb_rlv12;

    logic        clk = 1'b0;
    logic        busrst = 1'b1;
    logic        rlreq = 1'b0;
    logic [2:0]  rladdr = 3'd0;
    logic        rlwr = 1'b0;
    logic [15:0] rlwdata = 16'd0;
    logic        rlack;
    logic [15:0] rlrdata;
    logic        rlirq;
    logic        rlmemreq, rlmemwr;
    logic [31:0] rlmemaddr;
    logic [15:0] rlmemwdata;
    logic        rlmemack = 1'b0;
    logic [15:0] rlmemrdata = 16'd0;
    logic        rldmareq, rldmawr;
    logic [21:0] rldmaaddr;
    logic [15:0] rldmawdata;
    logic        rldmaack = 1'b0;
    logic [15:0] rldmardata = 16'd0;
    logic        rldmanxm = 1'b0;

    int checks = 0;
    int errors = 0;

    // responder configuration (written by the stimulus only)
    bit mem_hold = 1'b0;
    bit wc_mode  = 1'b0;
    int nxm_idx  = -1;
    int wc_idx   = -1;

    // responder logs (written by the responders only)
    int          irq_cnt  = 0;
    int          dma_wmis = 0;
    logic [15:0] last_img = 16'd0;
    logic [31:0] mem_q [$];
    logic [15:0] memw_q [$];
    logic [21:0] dma_q [$];

    rlv12 #(.NDRIVES(2)) dut (
        .clk(clk), .busrst(busrst),
        .rlreq(rlreq), .rladdr(rladdr), .rlwr(rlwr), .rlwdata(rlwdata),
        .rlack(rlack), .rlrdata(rlrdata), .rlirq(rlirq),
        .rlmemreq(rlmemreq), .rlmemwr(rlmemwr), .rlmemaddr(rlmemaddr), .rlmemwdata(rlmemwdata),
        .rlmemack(rlmemack), .rlmemrdata(rlmemrdata),
        .rldmareq(rldmareq), .rldmawr(rldmawr), .rldmaaddr(rldmaaddr), .rldmawdata(rldmawdata),
        .rldmaack(rldmaack), .rldmardata(rldmardata), .rldmanxm(rldmanxm)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] img_pat(input logic [31:0] a);
        return a[16:1] + 16'h1234;
    endfunction

    function automatic logic [15:0] dma_pat(input logic [21:0] a);
        return a[15:0] ^ 16'h5A5A ^ {10'd0, a[21:16]};
    endfunction

    // disk image model: one-cycle ack unless held
    always @(posedge clk) begin
        rlmemack <= 1'b0;
        if (rlmemreq) begin
            mem_q.push_back(rlmemaddr);
            if (rlmemwr) memw_q.push_back(rlmemwdata);
            if (!mem_hold) begin
                rlmemack   <= 1'b1;
                rlmemrdata <= img_pat(rlmemaddr);
                last_img   <= img_pat(rlmemaddr);
            end
        end
    end

    // PDP-11 memory model: one-cycle ack, optional NXM / write-check miscompare on a chosen request
    always @(posedge clk) begin
        rldmaack <= 1'b0;
        rldmanxm <= 1'b0;
        if (rldmareq) begin
            rldmaack <= 1'b1;
            rldmanxm <= (dma_q.size() == nxm_idx);
            if (wc_mode) rldmardata <= (dma_q.size() == wc_idx) ? (last_img ^ 16'h0001) : last_img;
            else         rldmardata <= dma_pat(rldmaaddr);
            if (rldmawr && (rldmawdata !== last_img)) dma_wmis <= dma_wmis + 1;
            dma_q.push_back(rldmaaddr);
        end
    end

    always @(posedge clk) if (rlirq === 1'b1) irq_cnt <= irq_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        rlreq = 1'b1; rlwr = 1'b1; rladdr = a; rlwdata = d;
        @(negedge clk);
        rlreq = 1'b0; rlwr = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [15:0] d);
        @(negedge clk);
        rlreq = 1'b1; rlwr = 1'b0; rladdr = a;
        @(negedge clk);
        rlreq = 1'b0;
        d = rlrdata;
        chk("rlack", {31'd0, rlack}, 32'd1);
    endtask

    task automatic wait_rdy(input int limit);
        logic [15:0] c;
        int n;
        c = 16'd0;
        n = 0;
        while (n < limit) begin
            rd(3'd0, c);
            if (c[7] === 1'b1) break;
            n++;
        end
        chk("crdy_wait", {31'd0, c[7]}, 32'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        int mb, wb, db, ib, bad, sz;

        repeat (3) @(negedge clk);
        busrst = 1'b0;

        // reset state
        rd(3'd0, d); chk("rst_csr", d, 32'h0081);
        rd(3'd4, d); chk("rst_bae", d, 32'h0);
        rd(3'd3, d); chk("rst_mp",  d, 32'h0);
        rd(3'd1, d); chk("rst_ba",  d, 32'h0);
        rd(3'd5, d); chk("rst_unused", d, 32'h0);

        // read setup: DA o103 -> track 1 sector 3 -> byte (3+40)*256 = 0x2B00
        wr(3'd2, 16'o000103);
        wr(3'd3, 16'hFF00);
        wr(3'd4, 16'h0001);
        wr(3'd1, 16'h0000);
        rd(3'd4, d); chk("bae_wr", d, 32'h1);
        rd(3'd3, d); chk("mp_wr",  d, 32'hFF00);

        // IE 0->1 without GO pulses rlirq once
        ib = irq_cnt;
        wr(3'd0, 16'h00D0);
        repeat (2) @(negedge clk);
        chk("ie_irq", irq_cnt - ib, 32'd1);
        rd(3'd0, d); chk("ie_csr", d, 32'h00D1);

        // F6 read of 256 words
        mb = mem_q.size(); db = dma_q.size(); ib = irq_cnt;
        wr(3'd0, 16'h005C);
        wait_rdy(5000);
        repeat (2) @(negedge clk);
        chk("rd_memcnt", mem_q.size() - mb, 32'd256);
        chk("rd_dmacnt", dma_q.size() - db, 32'd256);
        chk("rd_mem0", mem_q[mb], 32'h2B00);
        chk("rd_dma0", dma_q[db], 32'h10000);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (mem_q[mb + i] !== 32'h2B00 + 32'(2 * i)) bad++;
            if (dma_q[db + i] !== 22'h10000 + 22'(2 * i)) bad++;
        end
        chk("rd_addr_seq", bad, 32'd0);
        chk("rd_wdata", dma_wmis, 32'd0);
        chk("rd_irq", irq_cnt - ib, 32'd1);
        rd(3'd3, d); chk("rd_mp",  d, 32'h0);
        rd(3'd1, d); chk("rd_ba",  d, 32'h0200);
        rd(3'd4, d); chk("rd_bae", d, 32'h1);
        rd(3'd0, d); chk("rd_csr", d, 32'h00DD);

        // F5 write across a 64K boundary
        wr(3'd1, 16'hFFFE); wr(3'd4, 16'h0000); wr(3'd3, 16'hFFFE); wr(3'd2, 16'h0000);
        mb = mem_q.size(); wb = memw_q.size(); db = dma_q.size();
        wr(3'd0, 16'h004A);
        wait_rdy(200);
        chk("wr_dmacnt", dma_q.size() - db, 32'd2);
        chk("wr_dma0", dma_q[db],     32'h0FFFE);
        chk("wr_dma1", dma_q[db + 1], 32'h10000);
        chk("wr_memw0", memw_q[wb],     {16'd0, dma_pat(22'h0FFFE)});
        chk("wr_memw1", memw_q[wb + 1], {16'd0, dma_pat(22'h10000)});
        chk("wr_mema1", mem_q[mb + 1], 32'h2);
        rd(3'd4, d); chk("wr_bae", d, 32'h1);
        rd(3'd1, d); chk("wr_ba",  d, 32'h0002);
        rd(3'd3, d); chk("wr_mp",  d, 32'h0);

        // F1 write-check, 7 words, word index 3 miscompares
        wr(3'd1, 16'h1000); wr(3'd4, 16'h0000); wr(3'd3, 16'hFFF9); wr(3'd2, 16'h0000);
        wc_idx = dma_q.size() + 3; wc_mode = 1'b1;
        wr(3'd0, 16'h0042);
        wait_rdy(200);
        wc_mode = 1'b0; wc_idx = -1;
        rd(3'd0, d); chk("wc_csr", d, 32'h88C3);
        rd(3'd3, d); chk("wc_mp",  d, 32'hFFFD);
        rd(3'd1, d); chk("wc_ba",  d, 32'h1008);

        // NXM on the first DMA ack of a read
        wr(3'd1, 16'h2000); wr(3'd3, 16'hFFFC); wr(3'd2, 16'h0000);
        nxm_idx = dma_q.size();
        wr(3'd0, 16'h004C);
        wait_rdy(200);
        nxm_idx = -1;
        rd(3'd0, d); chk("nxm_csr", d, 32'hA0CD);
        rd(3'd3, d); chk("nxm_mp",  d, 32'hFFFC);
        rd(3'd1, d); chk("nxm_ba",  d, 32'h2000);

        // withheld image ack -> OPI after the timeout, not before
        mem_hold = 1'b1;
        wr(3'd3, 16'hFFFF);
        wr(3'd0, 16'h004C);
        repeat (200) @(negedge clk);
        rd(3'd0, d); chk("tmo_early", {31'd0, d[7]}, 32'd0);
        wait_rdy(8000);
        mem_hold = 1'b0;
        rd(3'd0, d); chk("tmo_csr", d, 32'h84CD);
        rd(3'd3, d); chk("tmo_mp",  d, 32'hFFFF);

        // busrst in the middle of a read
        wr(3'd3, 16'hFF00); wr(3'd1, 16'h0000);
        wr(3'd0, 16'h004C);
        repeat (40) @(negedge clk);
        busrst = 1'b1;
        @(negedge clk);
        busrst = 1'b0;
        sz = mem_q.size();
        repeat (20) @(negedge clk);
        chk("brst_quiet", mem_q.size(), sz);
        rd(3'd0, d); chk("brst_csr", d, 32'h0081);
        rd(3'd3, d); chk("brst_mp",  d, 32'h0);

        // nonexistent drive 3
        wr(3'd0, 16'h0380);
        rd(3'd0, d); chk("ds3_drdy", d, 32'h0380);
        wr(3'd0, 16'h0300);
        wait_rdy(50);
        rd(3'd0, d); chk("ds3_opi", d, 32'h8780);

        // SEEK +1 cylinder, then header and status
        wr(3'd2, 16'o000205);
        wr(3'd0, 16'h0006);
        wait_rdy(50);
        rd(3'd0, d); chk("seek_csr", d, 32'h0087);
        wr(3'd0, 16'h0008);
        wait_rdy(50);
        rd(3'd3, d); chk("rdhdr_mp", d, 32'o000200);
        wr(3'd0, 16'h0004);
        wait_rdy(50);
        rd(3'd3, d); chk("getstat_mp", d, 32'o000235);

        // SEEK without the marker bit -> OPI
        wr(3'd2, 16'h0084);
        wr(3'd0, 16'h0006);
        wait_rdy(50);
        rd(3'd0, d); chk("seek_nomark", d, 32'h8487);

        // SEEK -5 cylinders from track 2 clamps at 0, head 1 -> track 1
        wr(3'd2, 16'h0291);
        wr(3'd0, 16'h0006);
        wait_rdy(50);
        wr(3'd0, 16'h0008);
        wait_rdy(50);
        rd(3'd3, d); chk("seek_sat_hdr", d, 32'h0040);
        wr(3'd0, 16'h0004);
        wait_rdy(50);
        rd(3'd3, d); chk("seek_sat_stat", d, 32'h00DD);

        // sector 40 is out of range -> HNF, no image access
        mb = mem_q.size();
        wr(3'd2, 16'h0028); wr(3'd3, 16'hFFFF);
        wr(3'd0, 16'h000C);
        wait_rdy(50);
        rd(3'd0, d); chk("hnf_csr", d, 32'h948D);
        chk("hnf_noacc", mem_q.size() - mb, 32'd0);

        // MP = 0 completes without access
        wr(3'd2, 16'h0000); wr(3'd3, 16'h0000);
        wr(3'd0, 16'h000C);
        wait_rdy(50);
        rd(3'd0, d); chk("mp0_csr", d, 32'h008D);
        chk("mp0_noacc", mem_q.size() - mb, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
